// File: rtl/sync_ram_pipe.sv
// Single-port synchronous RAM with valid/ready request channel, byte enables and an in-order,
// credit-limited read-response queue. Define SYNC_RAM_PARITY_EN to add per-byte even parity.
module sync_ram_pipe #(
   parameter int ADDR_WIDTH   = 10,
   parameter int DATA_WIDTH   = 16,
   parameter int DEPTH        = 1 << ADDR_WIDTH,
   parameter int READ_LATENCY = 2,
   parameter int RSP_DEPTH    = READ_LATENCY + 2
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    req_valid_i,
   output logic                    req_ready_o,
   input  logic                    req_we_i,
   input  logic [ADDR_WIDTH-1:0]   req_addr_i,
   input  logic [DATA_WIDTH-1:0]   req_wdata_i,
   input  logic [DATA_WIDTH/8-1:0] req_be_i,
`ifdef SYNC_RAM_PARITY_EN
   input  logic                    par_inject_i,
`endif
   output logic                    rsp_valid_o,
   input  logic                    rsp_ready_i,
   output logic [DATA_WIDTH-1:0]   rsp_rdata_o,
   output logic                    rsp_err_o
);

   localparam int NB = DATA_WIDTH / 8;
   localparam int PW = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
   localparam int CW = $clog2(RSP_DEPTH + 1);
   localparam logic [CW-1:0]         CRED_MAX = CW'(RSP_DEPTH);
   localparam logic [PW-1:0]         PTR_LAST = PW'(RSP_DEPTH - 1);
   localparam logic [ADDR_WIDTH:0]   DEPTH_W  = (ADDR_WIDTH + 1)'(DEPTH);

   function automatic logic [PW-1:0] inc_ptr(input logic [PW-1:0] p);
      logic [PW-1:0] r;
      if (p == PTR_LAST) r = {PW{1'b0}};
      else               r = p + PW'(1);
      return r;
   endfunction

   logic [DATA_WIDTH-1:0]   mem_q [DEPTH];
   logic                    in_range_s, req_acc_s, rd_acc_s, wr_acc_s, push_s, pop_s;
   logic [DATA_WIDTH-1:0]   rd_word_s;
   logic                    rd_err_s, rd_par_err_s;
   logic [READ_LATENCY-1:0] pipe_vld_q, pipe_err_q;
   logic [DATA_WIDTH-1:0]   pipe_data_q [READ_LATENCY];
   logic [DATA_WIDTH-1:0]   fifo_data_q [RSP_DEPTH];
   logic                    fifo_err_q  [RSP_DEPTH];
   logic [PW-1:0]           wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]           occ_q, occ_d, cred_q, cred_d;
   logic                    req_ready_q, rsp_valid_q, rsp_err_q;
   logic [DATA_WIDTH-1:0]   rsp_rdata_q;
   logic [DATA_WIDTH-1:0]   head_data_d;
   logic                    head_err_d;

   assign in_range_s = ({1'b0, req_addr_i} < DEPTH_W);
   assign req_acc_s  = req_valid_i & req_ready_q;
   assign rd_acc_s   = req_acc_s & ~req_we_i;
   assign wr_acc_s   = req_acc_s & req_we_i & in_range_s;
   assign push_s     = pipe_vld_q[READ_LATENCY-1];
   assign pop_s      = rsp_valid_q & rsp_ready_i;

   // Storage array: byte-masked writes, deliberately not reset
   always_ff @(posedge clk) begin
      if (wr_acc_s) begin
         for (int i = 0; i < NB; i++) begin
            if (req_be_i[i]) mem_q[req_addr_i][8*i +: 8] <= req_wdata_i[8*i +: 8];
         end
      end
   end

`ifdef SYNC_RAM_PARITY_EN
   function automatic logic [NB-1:0] byte_parity(input logic [DATA_WIDTH-1:0] d);
      logic [NB-1:0] p;
      for (int i = 0; i < NB; i++) p[i] = ^d[8*i +: 8];
      return p;
   endfunction

   logic [NB-1:0] par_mem_q [DEPTH];
   logic [NB-1:0] wr_par_s;
   assign wr_par_s = byte_parity(req_wdata_i) ^ {NB{par_inject_i}};

   // Parity bits follow their data bytes; par_inject_i corrupts them for error testing
   always_ff @(posedge clk) begin
      if (wr_acc_s) begin
         for (int i = 0; i < NB; i++) begin
            if (req_be_i[i]) par_mem_q[req_addr_i][i] <= wr_par_s[i];
         end
      end
   end

   // Recompute parity of the addressed word and compare with the stored bits
   always_comb begin
      rd_par_err_s = 1'b0;
      if (in_range_s) rd_par_err_s = |(byte_parity(mem_q[req_addr_i]) ^ par_mem_q[req_addr_i]);
      else            rd_par_err_s = 1'b0;
   end
`else
   assign rd_par_err_s = 1'b0;
`endif

   // Read sample at accept; out-of-range reads return zero with error
   always_comb begin
      rd_word_s = {DATA_WIDTH{1'b0}};
      rd_err_s  = 1'b1;
      if (in_range_s) begin
         rd_word_s = mem_q[req_addr_i];
         rd_err_s  = rd_par_err_s;
      end else begin
         rd_word_s = {DATA_WIDTH{1'b0}};
         rd_err_s  = 1'b1;
      end
   end

   // Read latency pipeline; clearing valid bits on reset drops reads in flight
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pipe_vld_q <= {READ_LATENCY{1'b0}};
         pipe_err_q <= {READ_LATENCY{1'b0}};
         for (int k = 0; k < READ_LATENCY; k++) pipe_data_q[k] <= {DATA_WIDTH{1'b0}};
      end else begin
         pipe_vld_q[0]  <= rd_acc_s;
         pipe_err_q[0]  <= rd_err_s;
         pipe_data_q[0] <= rd_word_s;
         for (int k = 1; k < READ_LATENCY; k++) begin
            pipe_vld_q[k]  <= pipe_vld_q[k-1];
            pipe_err_q[k]  <= pipe_err_q[k-1];
            pipe_data_q[k] <= pipe_data_q[k-1];
         end
      end
   end

   // Next-state for queue pointers, occupancy, credits and the registered head entry
   always_comb begin
      occ_d  = occ_q;
      cred_d = cred_q;
      case ({push_s, pop_s})
         2'b10:   occ_d = occ_q + CW'(1);
         2'b01:   occ_d = occ_q - CW'(1);
         default: occ_d = occ_q;
      endcase
      case ({rd_acc_s, pop_s})
         2'b10:   cred_d = cred_q + CW'(1);
         2'b01:   cred_d = cred_q - CW'(1);
         default: cred_d = cred_q;
      endcase
      if (push_s) wr_ptr_d = inc_ptr(wr_ptr_q);
      else        wr_ptr_d = wr_ptr_q;
      if (pop_s)  rd_ptr_d = inc_ptr(rd_ptr_q);
      else        rd_ptr_d = rd_ptr_q;
      // An entry pushed this cycle becomes the head when the queue drains to it
      if (push_s && (wr_ptr_q == rd_ptr_d)) begin
         head_data_d = pipe_data_q[READ_LATENCY-1];
         head_err_d  = pipe_err_q[READ_LATENCY-1];
      end else begin
         head_data_d = fifo_data_q[rd_ptr_d];
         head_err_d  = fifo_err_q[rd_ptr_d];
      end
   end

   // Response queue state and registered outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < RSP_DEPTH; k++) begin
            fifo_data_q[k] <= {DATA_WIDTH{1'b0}};
            fifo_err_q[k]  <= 1'b0;
         end
         wr_ptr_q    <= {PW{1'b0}};
         rd_ptr_q    <= {PW{1'b0}};
         occ_q       <= {CW{1'b0}};
         cred_q      <= {CW{1'b0}};
         req_ready_q <= 1'b1;
         rsp_valid_q <= 1'b0;
         rsp_rdata_q <= {DATA_WIDTH{1'b0}};
         rsp_err_q   <= 1'b0;
      end else begin
         if (push_s) begin
            fifo_data_q[wr_ptr_q] <= pipe_data_q[READ_LATENCY-1];
            fifo_err_q[wr_ptr_q]  <= pipe_err_q[READ_LATENCY-1];
         end
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         occ_q       <= occ_d;
         cred_q      <= cred_d;
         req_ready_q <= (cred_d < CRED_MAX);
         rsp_valid_q <= (occ_d != {CW{1'b0}});
         rsp_rdata_q <= head_data_d;
         rsp_err_q   <= head_err_d;
      end
   end

   assign req_ready_o = req_ready_q;
   assign rsp_valid_o = rsp_valid_q;
   assign rsp_rdata_o = rsp_rdata_q;
   assign rsp_err_o   = rsp_err_q;

endmodule

// File: tb/tb_sync_ram_pipe.sv
// Randomised self-checking bench for sync_ram_pipe (DEPTH=1000) against a transaction-level
// memory/queue model; the parity scenario is compiled in when SYNC_RAM_PARITY_EN is defined.
module tb_sync_ram_pipe;
   localparam int AW = 10, DW = 16, DEPTH = 1000, RL = 2, RD = 4;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          req_valid, req_we, rsp_ready, par_inject;
   logic [AW-1:0] req_addr;
   logic [DW-1:0] req_wdata;
   logic [1:0]    req_be;
   logic          req_ready_o, rsp_valid_o, rsp_err_o;
   logic [DW-1:0] rsp_rdata_o;

   int checks = 0, failures = 0;
   int outstanding = 0;
   logic [DW-1:0] model_mem [DEPTH];
   logic [1:0]    model_bad [DEPTH];
   logic [16:0]   exp_q[$], got_q[$];

   always #5 clk = ~clk;

   sync_ram_pipe #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH), .READ_LATENCY(RL), .RSP_DEPTH(RD)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid_i(req_valid), .req_ready_o(req_ready_o), .req_we_i(req_we),
      .req_addr_i(req_addr), .req_wdata_i(req_wdata), .req_be_i(req_be),
`ifdef SYNC_RAM_PARITY_EN
      .par_inject_i(par_inject),
`endif
      .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready), .rsp_rdata_o(rsp_rdata_o), .rsp_err_o(rsp_err_o));

   // Record accepted requests and popped responses into the model, then advance one clock.
   task automatic step();
      if (rst_n && req_valid && req_ready_o) begin
         if (req_we) begin
            if (req_addr < DEPTH) begin
               for (int i = 0; i < 2; i++) begin
                  if (req_be[i]) begin
                     model_mem[req_addr][8*i +: 8] = req_wdata[8*i +: 8];
                     model_bad[req_addr][i] = par_inject;
                  end
               end
            end
         end else begin
            if (req_addr < DEPTH) exp_q.push_back({|model_bad[req_addr], model_mem[req_addr]});
            else                  exp_q.push_back({1'b1, 16'h0000});
            outstanding++;
         end
      end
      if (rst_n && rsp_valid_o && rsp_ready) begin
         got_q.push_back({rsp_err_o, rsp_rdata_o});
         outstanding--;
      end
      @(posedge clk); #1;
   endtask

   task automatic drive(input logic we, input int addr, input logic [DW-1:0] d, input logic [1:0] be);
      req_valid = 1'b1; req_we = we; req_addr = AW'(addr); req_wdata = d; req_be = be;
   endtask

   task automatic drain(output bit timeout);
      req_valid = 1'b0; rsp_ready = 1'b1; timeout = 1'b0;
      for (int n = 0; got_q.size() < exp_q.size(); n++) begin
         if (n > 200) begin timeout = 1'b1; break; end
         step();
      end
      step(); step();
   endtask

   task automatic test_reset();
      rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0; req_be = 2'b00;
      rsp_ready = 1'b1; par_inject = 1'b0;
      #23;
      checks++;
      if (rsp_valid_o !== 1'b0 || rsp_rdata_o !== 16'h0000 || rsp_err_o !== 1'b0) begin
         failures++; $display("FAIL reset_outputs got v=%b d=%h e=%b want 0/0000/0", rsp_valid_o, rsp_rdata_o, rsp_err_o);
      end
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;
      checks++;
      if (req_ready_o !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b want=1", req_ready_o); end
   endtask

   task automatic test_fill();
      for (int a = 0; a < DEPTH; a++) begin
         drive(1'b1, a, DW'($urandom), 2'b11);
         step();
      end
      req_valid = 1'b0;
      checks++;
      if (req_ready_o !== 1'b1) begin failures++; $display("FAIL fill_ready got=%b want=1", req_ready_o); end
   endtask

   task automatic test_basic();
      int n;
      bit to;
      drive(1'b1, 5, 16'hBEEF, 2'b11); step();
      drive(1'b0, 5, 16'h0000, 2'b00);
      checks++;
      if (req_ready_o !== 1'b1) begin failures++; $display("FAIL basic_ready got=%b want=1", req_ready_o); end
      step();
      req_valid = 1'b0; n = 0;
      while (!rsp_valid_o && n < 20) begin step(); n++; end
      checks++;
      if (n !== RL) begin failures++; $display("FAIL basic_latency got=%0d want=%0d", n, RL); end
      checks++;
      if (rsp_rdata_o !== 16'hBEEF || rsp_err_o !== 1'b0) begin
         failures++; $display("FAIL basic_data got=%h/%b want=beef/0", rsp_rdata_o, rsp_err_o);
      end
      step();
      drive(1'b1, 5, 16'h1234, 2'b01); step();
      drive(1'b0, 5, 16'h0000, 2'b00); step();
      drain(to);
      checks++;
      if (to || got_q.size() != 2) begin failures++; $display("FAIL basic_count got=%0d want=2", got_q.size()); end
      else begin
         checks++;
         if (got_q[1] !== 17'h0BE34) begin failures++; $display("FAIL basic_bytewrite got=%h want=0be34", got_q[1]); end
      end
      for (int i = 0; i < exp_q.size(); i++) begin
         checks++;
         if (got_q[i] !== exp_q[i]) begin failures++; $display("FAIL basic_rsp[%0d] got=%h want=%h", i, got_q[i], exp_q[i]); end
      end
      exp_q.delete(); got_q.delete();
   endtask

   task automatic test_backpressure();
      int issued = 0, n = 0;
      bit acc, to;
      rsp_ready = 1'b0;
      for (int c = 0; c < 10; c++) begin
         drive(1'b0, issued, 16'h0000, 2'b00);
         checks++;
         if (req_ready_o !== (outstanding < RD)) begin
            failures++; $display("FAIL bp_ready cyc=%0d got=%b want=%b", c, req_ready_o, outstanding < RD);
         end
         acc = req_ready_o;
         step();
         if (acc) issued++;
      end
      checks++;
      if (issued != RD || req_ready_o !== 1'b0) begin
         failures++; $display("FAIL bp_accepts got=%0d/ready=%b want=%0d/0", issued, req_ready_o, RD);
      end
      for (int c = 0; c < 4; c++) begin
         step();
         checks++;
         if (rsp_valid_o !== 1'b1 || rsp_rdata_o !== model_mem[0] || rsp_err_o !== 1'b0) begin
            failures++; $display("FAIL bp_stall cyc=%0d got=%b/%h want=1/%h", c, rsp_valid_o, rsp_rdata_o, model_mem[0]);
         end
      end
      rsp_ready = 1'b1;
      while (issued < 10 && n < 50) begin
         drive(1'b0, issued, 16'h0000, 2'b00);
         acc = req_ready_o;
         step(); n++;
         if (acc) issued++;
      end
      drain(to);
      checks++;
      if (to || got_q.size() != 10) begin failures++; $display("FAIL bp_count got=%0d want=10", got_q.size()); end
      for (int i = 0; i < exp_q.size(); i++) begin
         checks++;
         if (got_q[i] !== exp_q[i]) begin failures++; $display("FAIL bp_rsp[%0d] got=%h want=%h", i, got_q[i], exp_q[i]); end
      end
      exp_q.delete(); got_q.delete();
   endtask

   task automatic test_back_to_back();
      int acc_cnt = 0;
      bit to;
      rsp_ready = 1'b1;
      for (int c = 0; c < 64; c++) begin
         drive(1'b0, $urandom_range(0, DEPTH - 1), 16'h0000, 2'b00);
         if (req_ready_o === 1'b1) acc_cnt++;
         step();
      end
      checks++;
      if (acc_cnt != 64) begin failures++; $display("FAIL b2b_accepts got=%0d want=64", acc_cnt); end
      drain(to);
      checks++;
      if (to || got_q.size() != 64) begin failures++; $display("FAIL b2b_count got=%0d want=64", got_q.size()); end
      for (int i = 0; i < exp_q.size(); i++) begin
         checks++;
         if (got_q[i] !== exp_q[i]) begin failures++; $display("FAIL b2b_rsp[%0d] got=%h want=%h", i, got_q[i], exp_q[i]); end
      end
      exp_q.delete(); got_q.delete();
   endtask

   task automatic test_out_of_range();
      bit to;
      drive(1'b1, 1010, 16'hAAAA, 2'b11); step();
      drive(1'b0, 1010, 16'h0000, 2'b00); step();
      for (int c = 0; c < 4; c++) begin drive(1'b0, $urandom_range(DEPTH, 1023), 16'h0000, 2'b00); step(); end
      for (int a = 0; a < DEPTH; a++) begin
         drive(1'b0, a, 16'h0000, 2'b00);
         while (req_ready_o !== 1'b1) step();
         step();
      end
      drain(to);
      checks++;
      if (to || got_q.size() != DEPTH + 5) begin failures++; $display("FAIL oor_count got=%0d want=%0d", got_q.size(), DEPTH + 5); end
      else begin
         checks++;
         if (got_q[0] !== 17'h10000) begin failures++; $display("FAIL oor_read got=%h want=10000", got_q[0]); end
      end
      for (int i = 0; i < exp_q.size(); i++) begin
         checks++;
         if (got_q[i] !== exp_q[i]) begin failures++; $display("FAIL oor_rsp[%0d] got=%h want=%h", i, got_q[i], exp_q[i]); end
      end
      exp_q.delete(); got_q.delete();
   endtask

   task automatic test_random();
      bit to;
      for (int c = 0; c < 400; c++) begin
         req_valid = 1'($urandom_range(0, 3) != 0);
         req_we    = 1'($urandom_range(0, 2) == 0);
         req_addr  = ($urandom_range(0, 7) == 0) ? AW'($urandom_range(DEPTH, 1023)) : AW'($urandom_range(0, 15));
         req_wdata = DW'($urandom);
         req_be    = 2'($urandom);
         rsp_ready = 1'($urandom_range(0, 2) != 0);
         checks++;
         if (req_ready_o !== (outstanding < RD)) begin
            failures++; $display("FAIL rnd_ready cyc=%0d got=%b want=%b", c, req_ready_o, outstanding < RD);
         end
         step();
      end
      drain(to);
      checks++;
      if (to || got_q.size() != exp_q.size()) begin failures++; $display("FAIL rnd_count got=%0d want=%0d", got_q.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size(); i++) begin
         checks++;
         if (got_q[i] !== exp_q[i]) begin failures++; $display("FAIL rnd_rsp[%0d] got=%h want=%h", i, got_q[i], exp_q[i]); end
      end
      exp_q.delete(); got_q.delete();
   endtask

   task automatic test_reset_inflight();
      bit to;
      rsp_ready = 1'b1;
      drive(1'b0, 7, 16'h0000, 2'b00); step();
      drive(1'b0, 8, 16'h0000, 2'b00); step();
      req_valid = 1'b0;
      #2 rst_n = 1'b0;
      exp_q.delete(); outstanding = 0;
      #20;
      checks++;
      if (rsp_valid_o !== 1'b0) begin failures++; $display("FAIL rst_flight_valid got=%b want=0", rsp_valid_o); end
      @(negedge clk); rst_n = 1'b1;
      for (int c = 0; c < 8; c++) begin
         step();
         checks++;
         if (rsp_valid_o !== 1'b0 || req_ready_o !== 1'b1) begin
            failures++; $display("FAIL rst_flight_idle cyc=%0d got v=%b r=%b want 0/1", c, rsp_valid_o, req_ready_o);
         end
      end
      checks++;
      if (got_q.size() != 0) begin failures++; $display("FAIL rst_flight_rsp got=%0d want=0", got_q.size()); end
      got_q.delete();
      drive(1'b0, 7, 16'h0000, 2'b00); step();
      drain(to);
      checks++;
      if (to || got_q.size() != 1 || got_q[0] !== exp_q[0]) begin
         failures++; $display("FAIL rst_flight_mem got=%h want=%h", (got_q.size() > 0) ? got_q[0] : 17'h0, exp_q[0]);
      end
      exp_q.delete(); got_q.delete();
   endtask

`ifdef SYNC_RAM_PARITY_EN
   task automatic test_parity();
      bit to;
      par_inject = 1'b1; drive(1'b1, 3, 16'h00FF, 2'b11); step();
      par_inject = 1'b0; drive(1'b0, 3, 16'h0000, 2'b00); step();
      drive(1'b0, 5, 16'h0000, 2'b00); step();
      drain(to);
      checks++;
      if (to || got_q.size() != 2 || got_q[0] !== 17'h100FF) begin
         failures++; $display("FAIL parity_inject got=%h want=100ff", (got_q.size() > 0) ? got_q[0] : 17'h0);
      end
      for (int i = 0; i < exp_q.size(); i++) begin
         checks++;
         if (got_q[i] !== exp_q[i]) begin failures++; $display("FAIL parity_rsp[%0d] got=%h want=%h", i, got_q[i], exp_q[i]); end
      end
      exp_q.delete(); got_q.delete();
   endtask
`endif

   initial begin
      test_reset();
      test_fill();
      test_basic();
      test_backpressure();
      test_back_to_back();
      test_out_of_range();
      test_random();
      test_reset_inflight();
`ifdef SYNC_RAM_PARITY_EN
      test_parity();
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "watchdog");
   end
endmodule

// File: doc/sync_ram_pipe.md
Name: sync_ram_pipe

Overview:
- Parametrised single-port synchronous RAM with a valid/ready request channel and an in-order valid/ready read-response channel.
- Adds byte-write enables, a configurable read pipeline latency, response backpressure and out-of-range detection.
- Sits between CPU/datapath masters and on-chip storage.
- Replaces bidirectional addr/data buses with unidirectional ports.

Parameters:
- ADDR_WIDTH, 10, request address width.
- DATA_WIDTH, 16, data width; must be a multiple of 8.
- DEPTH, 1<<ADDR_WIDTH, number of words; must be <= 2^ADDR_WIDTH.
- READ_LATENCY, 2, cycles from read accept to response entering the response queue; must be >= 1.
- RSP_DEPTH, READ_LATENCY+2, response queue entries and read credit limit.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- req_valid  input  1  request present.
- req_ready  output  1  request accepted when req_valid & req_ready.
- req_we  input  1  1 = write, 0 = read.
- req_addr  input  ADDR_WIDTH  word address.
- req_wdata  input  DATA_WIDTH  write data.
- req_be  input  DATA_WIDTH/8  byte enables for writes; bit i covers bits [8i+7:8i].
- rsp_valid  output  1  read response available.
- rsp_ready  input  1  response consumed when rsp_valid & rsp_ready.
- rsp_rdata  output  DATA_WIDTH  read data.
- rsp_err  output  1  response error flag, qualified by rsp_valid.

Behaviour:
- Reset (rst_n low, asynchronous):
  - rsp_valid=0, rsp_rdata=0, rsp_err=0.
  - Credit counter=0, so req_ready=1 once reset is released.
  - Pipeline valid bits and queue pointers cleared.
  - Memory contents are not reset.
  - Reads in flight when reset asserts are discarded; no response is ever produced for them.
- Credit counter cnt (0..RSP_DEPTH):
  - +1 on read accept; -1 on response pop; unchanged on simultaneous accept and pop.
  - req_ready = (cnt < RSP_DEPTH), registered-only: no combinational path from req_valid, req_we or rsp_ready. Applies to writes as well.
- Write accept:
  - At that edge, for each byte i with req_be[i]=1, mem[req_addr] byte i <= req_wdata byte i. Other bytes unchanged.
  - req_be=0 is a legal no-op.
  - No response is generated.
- Read accept:
  - Memory is sampled at the accept edge, after any write accepted in a previous cycle.
  - A read accepted in the cycle after a write to the same address returns the new data.
  - Data travels a READ_LATENCY-stage valid pipeline and is pushed into the response queue READ_LATENCY cycles after accept.
  - If the queue is empty and rsp_ready=1, rsp_valid first rises READ_LATENCY cycles after accept.
- Response queue:
  - FIFO, RSP_DEPTH entries, in order.
  - rsp_valid = queue not empty; rsp_rdata/rsp_err show the head entry.
  - While rsp_valid & !rsp_ready, the outputs stay stable.
  - Credits guarantee the queue never overflows; pointers wrap modulo RSP_DEPTH.
  - Push and pop in the same cycle are both performed; occupancy is unchanged.
- Throughput:
  - With rsp_ready held at 1, back-to-back reads sustain 1 accept per cycle indefinitely.
  - With rsp_ready held at 0, exactly RSP_DEPTH reads are accepted, then req_ready=0 until a pop.
- Out of range (req_addr >= DEPTH):
  - A write is dropped with no memory change.
  - A read returns rsp_rdata=0 and rsp_err=1 at its normal response slot.
- Only one request is accepted per cycle, so there is no same-cycle read/write conflict.

Optional Feature:
- Macro: SYNC_RAM_PARITY_EN.
- Defined:
  - Each memory byte stores an extra even-parity bit, written together with its byte under req_be.
  - On read, parity is recomputed per byte. Any mismatch sets rsp_err=1; rsp_rdata carries the raw stored data.
  - An extra port is present: par_inject, input, 1 bit. When it is 1 on a write accept, the stored parity bits of the enabled bytes are inverted.
  - Out-of-range behaviour is unchanged.
- Not defined:
  - No parity storage and no par_inject port.
  - rsp_err is set only for out-of-range reads.

Test Plan:
- Reset release, then write addr 5 = 0xBEEF with be=2'b11, then read addr 5 (READ_LATENCY=2, rsp_ready=1) -> rsp_valid rises 2 cycles after read accept, rsp_rdata=0xBEEF, rsp_err=0.
- Write addr 5 = 0x1234 with be=2'b01, then read addr 5 in the next cycle -> rsp_rdata=0xBE34.
- rsp_ready=0, issue 10 reads of addrs 0..9 -> exactly 4 accepted (RSP_DEPTH=4), then req_ready=0. rsp_ready=1 -> responses for addrs 0..3 returned in order, rsp_rdata stable while stalled; remaining reads then accepted.
- rsp_ready=1, 64 back-to-back reads -> 64 accepts in 64 consecutive cycles, 64 in-order responses.
- DEPTH=1000, write 0xAAAA to addr 1010, then read addr 1010 -> rsp_rdata=0, rsp_err=1; no in-range word modified.
- Assert rst_n=0 with 2 reads in flight, then release -> no response emerges, rsp_valid=0, req_ready=1. With SYNC_RAM_PARITY_EN: write 0x00FF to addr 3 with par_inject=1, read addr 3 -> rsp_rdata=0x00FF, rsp_err=1.
